freq_disp_ctrl: RTL

//  Display sequencer between the frequency measurement core and the 8-digit multiplexed hex display driver.

---
 rtl/freq_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 46 ++++
 rtl/freq_disp_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared constants, FSM encoding and helpers for the frequency display sequencer.
package freq_pkg;

  localparam logic [3:0]  DP_OFF      = 4'hF;
  localparam logic [31:0] MAX_DISP    = 32'd99_999_999;
  localparam logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE;
  localparam logic [31:0] KHZ_TH      = 32'd1_000;
  localparam logic [31:0] MHZ_TH      = 32'd1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [31:0] dd_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    r = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Auto-range separators: returns {point_1, point_2}.
  function automatic logic [7:0] dp_sel(input logic [31:0] value);
    if (value >= MHZ_TH)
      return {4'd3, 4'd2};
    else if (value >= KHZ_TH)
      return {4'd3, DP_OFF};
    else
      return {DP_OFF, DP_OFF};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift per clock, CNT_W clocks after start.
// done is high during the cycle whose closing edge performs the last shift.
module bin2bcd_seq
  import freq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] bin_in,
  output logic [31:0]      bcd,
  output logic             done
);

  localparam int CW = $clog2(CNT_W);

  logic [CNT_W-1:0] bin_sr;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [31:0]      bcd_adj;

  assign bcd_adj = dd_adjust(bcd);
  assign done    = running && (cnt == CW'(CNT_W - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bin_sr  <= '0;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      bin_sr  <= bin_in;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      bcd    <= {bcd_adj[30:0], bin_sr[CNT_W-1]};
      bin_sr <= {bin_sr[CNT_W-2:0], 1'b0};
      cnt    <= cnt + 1'b1;
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_disp_ctrl.sv
// Display sequencer: converts each measured count to BCD, picks separators, and
// commits Disp_Data/points/ovf atomically; a one-deep slot absorbs strobes while busy.
module freq_disp_ctrl
  import freq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [CNT_W-1:0] freq_bin,
  input  logic             freq_valid,
  input  logic             hold,
  output logic [31:0]      Disp_Data,
  output logic [3:0]       point_1,
  output logic [3:0]       point_2,
  output logic             busy,
  output logic             upd_done,
  output logic             ovf
);

  state_t           state;
  logic [CNT_W-1:0] cap_bin;
  logic [CNT_W-1:0] pend_dat;
  logic             pend_vld;
  logic             start;
  logic [CNT_W-1:0] start_dat;
  logic [31:0]      bcd;
  logic             conv_done;
  logic [7:0]       dp;

  assign start     = (state == ST_IDLE) && (pend_vld || freq_valid);
  assign start_dat = pend_vld ? pend_dat : freq_bin;
  assign dp        = dp_sel(cap_bin);

  bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .bin_in  (start_dat),
    .bcd     (bcd),
    .done    (conv_done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      Disp_Data <= '0;
      point_1   <= DP_OFF;
      point_2   <= DP_OFF;
      busy      <= 1'b0;
      upd_done  <= 1'b0;
      ovf       <= 1'b0;
      pend_vld  <= 1'b0;
      pend_dat  <= '0;
      cap_bin   <= '0;
    end else begin
      upd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cap_bin <= start_dat;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
            // Draining the slot; a coincident strobe refills it rather than being lost.
            if (pend_vld) begin
              pend_vld <= freq_valid;
              if (freq_valid)
                pend_dat <= freq_bin;
            end
          end
        end
        ST_SHIFT: begin
          if (conv_done)
            state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (!hold) begin
            if (cap_bin > MAX_DISP) begin
              Disp_Data <= OVF_PATTERN;
              point_1   <= DP_OFF;
              point_2   <= DP_OFF;
              ovf       <= 1'b1;
            end else begin
              Disp_Data <= bcd;
              point_1   <= dp[7:4];
              point_2   <= dp[3:0];
              ovf       <= 1'b0;
            end
          end
          upd_done <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (state != ST_IDLE && freq_valid) begin
        pend_vld <= 1'b1;
        pend_dat <= freq_bin;
      end
    end
  end

endmodule
